// File: rtl/pipeline_ctrl_if.sv
// Hazard-sequencer bundle: hazard sources from ID/EX/MEM in, per-stage ctrl codes out.
// master = pipeline side, slave = pipeline_ctrl.
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       id_rs1_addr_i;
  logic [4:0]       id_rs2_addr_i;
  logic             id_use_rs1_i;
  logic             id_use_rs2_i;
  logic             ex_is_load_i;
  logic [4:0]       ex_rd_addr_i;
  logic             ex_wreg_i;
  logic             branch_taken_i;
  logic             mem_req_i;
  logic             mem_ready_i;
  logic             md_start_i;
  logic             md_done_i;
  logic [1:0]       ctrl_pc_o;
  logic [1:0]       ctrl_if_id_o;
  logic [1:0]       ctrl_id_ex_o;
  logic [1:0]       ctrl_ex_mem_o;
  logic [1:0]       ctrl_mem_wb_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic             err_timeout_o;

  modport master (
    output id_rs1_addr_i, id_rs2_addr_i, id_use_rs1_i, id_use_rs2_i,
           ex_is_load_i, ex_rd_addr_i, ex_wreg_i, branch_taken_i,
           mem_req_i, mem_ready_i, md_start_i, md_done_i,
    input  ctrl_pc_o, ctrl_if_id_o, ctrl_id_ex_o, ctrl_ex_mem_o, ctrl_mem_wb_o,
           stall_cnt_o, err_timeout_o
  );

  modport slave (
    input  id_rs1_addr_i, id_rs2_addr_i, id_use_rs1_i, id_use_rs2_i,
           ex_is_load_i, ex_rd_addr_i, ex_wreg_i, branch_taken_i,
           mem_req_i, mem_ready_i, md_start_i, md_done_i,
    output ctrl_pc_o, ctrl_if_id_o, ctrl_id_ex_o, ctrl_ex_mem_o, ctrl_mem_wb_o,
           stall_cnt_o, err_timeout_o
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central hazard/stall sequencer: drives Default/Stalled/Bubble into the five pipeline
// registers for load-use, taken-branch, data-memory waits and mul/div waits.
module pipeline_ctrl #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CNT_W   = 32
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.slave bus
);

  localparam logic [1:0] CTRL_STATE_DEFAULT = 2'b00;
  localparam logic [1:0] CTRL_STATE_STALLED = 2'b01;
  localparam logic [1:0] CTRL_STATE_BUBBLE  = 2'b10;

  localparam int unsigned       WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    MD_WAIT
  } state_t;

  typedef enum logic [2:0] {
    RULE_MEM,
    RULE_MD,
    RULE_BRANCH,
    RULE_LOAD_USE,
    RULE_NONE
  } rule_t;

  state_t             state;
  state_t             next_state;
  rule_t              rule;
  rule_t              late_rule;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]   stall_cnt;
  logic               err_timeout;
  logic               timeout_hit;
  logic               mem_stall;
  logic               md_stall;
  logic               load_use;
  logic               wait_last;
  logic [1:0]         ctrl_pc;
  logic [1:0]         ctrl_if_id;
  logic [1:0]         ctrl_id_ex;
  logic [1:0]         ctrl_ex_mem;
  logic [1:0]         ctrl_mem_wb;

  assign mem_stall = bus.mem_req_i & ~bus.mem_ready_i;
  assign md_stall  = bus.md_start_i & ~bus.md_done_i;
  assign wait_last = (wait_cnt == WAIT_LAST);

  assign load_use = bus.ex_is_load_i & bus.ex_wreg_i & (bus.ex_rd_addr_i != 5'd0) &
                    ((bus.id_use_rs1_i & (bus.id_rs1_addr_i == bus.ex_rd_addr_i)) |
                     (bus.id_use_rs2_i & (bus.id_rs2_addr_i == bus.ex_rd_addr_i)));

  // Branch outranks load-use: the dependent younger instruction is flushed anyway.
  always_comb begin
    late_rule = RULE_NONE;
    if (bus.branch_taken_i)
      late_rule = RULE_BRANCH;
    else if (load_use)
      late_rule = RULE_LOAD_USE;
  end

  // Completion cycles re-arbitrate the remaining rules in the same cycle; the watchdog
  // cycle drops both wait rules so the pipeline is released back to RUN.
  always_comb begin
    rule        = late_rule;
    timeout_hit = 1'b0;
    case (state)
      RUN: begin
        if (mem_stall)
          rule = RULE_MEM;
        else if (md_stall)
          rule = RULE_MD;
      end
      MEM_WAIT: begin
        if (bus.mem_ready_i) begin
          if (md_stall)
            rule = RULE_MD;
        end else if (wait_last) begin
          timeout_hit = 1'b1;
        end else begin
          rule = RULE_MEM;
        end
      end
      MD_WAIT: begin
        if (bus.md_done_i) begin
          if (mem_stall)
            rule = RULE_MEM;
        end else if (wait_last) begin
          timeout_hit = 1'b1;
        end else begin
          rule = RULE_MD;
        end
      end
      default: rule = late_rule;
    endcase
  end

  always_comb begin
    next_state = RUN;
    case (rule)
      RULE_MEM: next_state = MEM_WAIT;
      RULE_MD:  next_state = MD_WAIT;
      default:  next_state = RUN;
    endcase
  end

  always_comb begin
    ctrl_pc     = CTRL_STATE_DEFAULT;
    ctrl_if_id  = CTRL_STATE_DEFAULT;
    ctrl_id_ex  = CTRL_STATE_DEFAULT;
    ctrl_ex_mem = CTRL_STATE_DEFAULT;
    ctrl_mem_wb = CTRL_STATE_DEFAULT;
    if (rst) begin
      ctrl_pc     = CTRL_STATE_BUBBLE;
      ctrl_if_id  = CTRL_STATE_BUBBLE;
      ctrl_id_ex  = CTRL_STATE_BUBBLE;
      ctrl_ex_mem = CTRL_STATE_BUBBLE;
      ctrl_mem_wb = CTRL_STATE_BUBBLE;
    end else begin
      case (rule)
        RULE_MEM: begin
          ctrl_pc     = CTRL_STATE_STALLED;
          ctrl_if_id  = CTRL_STATE_STALLED;
          ctrl_id_ex  = CTRL_STATE_STALLED;
          ctrl_ex_mem = CTRL_STATE_STALLED;
          ctrl_mem_wb = CTRL_STATE_BUBBLE;
        end
        RULE_MD: begin
          ctrl_pc     = CTRL_STATE_STALLED;
          ctrl_if_id  = CTRL_STATE_STALLED;
          ctrl_id_ex  = CTRL_STATE_STALLED;
          ctrl_ex_mem = CTRL_STATE_BUBBLE;
        end
        RULE_BRANCH: begin
          ctrl_if_id  = CTRL_STATE_BUBBLE;
          ctrl_id_ex  = CTRL_STATE_BUBBLE;
        end
        RULE_LOAD_USE: begin
          ctrl_pc     = CTRL_STATE_STALLED;
          ctrl_if_id  = CTRL_STATE_STALLED;
          ctrl_id_ex  = CTRL_STATE_BUBBLE;
        end
        default: ctrl_pc = CTRL_STATE_DEFAULT;
      endcase
    end
  end

  // Wait counter only advances while staying in a wait state; leaving at WAIT_LAST keeps it from wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      stall_cnt   <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= next_state;
      if ((next_state == state) && (state != RUN))
        wait_cnt <= wait_cnt + WAIT_W'(1);
      else
        wait_cnt <= '0;
      if ((ctrl_pc == CTRL_STATE_STALLED) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (timeout_hit)
        err_timeout <= 1'b1;
    end
  end

  assign bus.ctrl_pc_o     = ctrl_pc;
  assign bus.ctrl_if_id_o  = ctrl_if_id;
  assign bus.ctrl_id_ex_o  = ctrl_id_ex;
  assign bus.ctrl_ex_mem_o = ctrl_ex_mem;
  assign bus.ctrl_mem_wb_o = ctrl_mem_wb;
  assign bus.stall_cnt_o   = stall_cnt;
  assign bus.err_timeout_o = err_timeout;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed hazard scenarios then random traffic,
// every cycle compared against a rule-table reference model.
module tb_pipeline_ctrl;

  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned CNT_W   = 6;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [1:0] D = 2'b00;
  localparam logic [1:0] S = 2'b01;
  localparam logic [1:0] B = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_ctrl #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: which wait (if any) is pending, how long, and the registered outputs.
  bit         m_in_mem  = 1'b0;
  bit         m_in_md   = 1'b0;
  int         m_waited  = 0;
  int         m_cnt     = 0;
  bit         m_err     = 1'b0;
  int         m_rule    = 5;
  bit         m_timeout = 1'b0;
  bit         m_forced  = 1'b0;
  logic [9:0] m_pat;

  // Rule 0 = reset; 1..5 as the hazard rules. Order {PC, IF_ID, ID_EX, EX_MEM, MEM_WB}.
  function automatic logic [9:0] pattern(int r);
    case (r)
      0:       return {B, B, B, B, B};
      1:       return {S, S, S, S, B};
      2:       return {S, S, S, B, D};
      3:       return {D, B, B, D, D};
      4:       return {S, S, B, D, D};
      default: return {D, D, D, D, D};
    endcase
  endfunction

  function automatic bit rule_cond(int r);
    case (r)
      1: return bus.mem_req_i && !bus.mem_ready_i;
      2: return bus.md_start_i && !bus.md_done_i;
      3: return bus.branch_taken_i;
      4: return bus.ex_is_load_i && bus.ex_wreg_i && (bus.ex_rd_addr_i != 0) &&
                ((bus.id_use_rs1_i && bus.id_rs1_addr_i == bus.ex_rd_addr_i) ||
                 (bus.id_use_rs2_i && bus.id_rs2_addr_i == bus.ex_rd_addr_i));
      default: return 1'b1;
    endcase
  endfunction

  // First rule (in priority order) that is both permitted and triggered.
  function automatic int pick(bit [5:1] allowed);
    for (int r = 1; r <= 5; r++)
      if (allowed[r] && rule_cond(r)) return r;
    return 5;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_idle();
    bus.id_rs1_addr_i  = '0;
    bus.id_rs2_addr_i  = '0;
    bus.id_use_rs1_i   = 1'b0;
    bus.id_use_rs2_i   = 1'b0;
    bus.ex_is_load_i   = 1'b0;
    bus.ex_rd_addr_i   = '0;
    bus.ex_wreg_i      = 1'b0;
    bus.branch_taken_i = 1'b0;
    bus.mem_req_i      = 1'b0;
    bus.mem_ready_i    = 1'b0;
    bus.md_start_i     = 1'b0;
    bus.md_done_i      = 1'b0;
  endtask

  task automatic set_load_use(logic [4:0] rd);
    bus.ex_is_load_i  = 1'b1;
    bus.ex_wreg_i     = 1'b1;
    bus.ex_rd_addr_i  = rd;
    bus.id_use_rs1_i  = 1'b1;
    bus.id_rs1_addr_i = 5'd5;
  endtask

  task automatic cycle_check();
    @(negedge clk);
    m_timeout = 1'b0;
    m_forced  = 1'b0;
    if (rst) begin
      m_rule = 0;
    end else if (m_in_mem) begin
      if (bus.mem_ready_i)                 m_rule = pick(5'b11110);
      else if (m_waited == TIMEOUT - 1) begin m_rule = pick(5'b11100); m_timeout = 1'b1; end
      else begin m_rule = 1; m_forced = 1'b1; end
    end else if (m_in_md) begin
      if (bus.md_done_i)                   m_rule = pick(5'b11101);
      else if (m_waited == TIMEOUT - 1) begin m_rule = pick(5'b11100); m_timeout = 1'b1; end
      else begin m_rule = 2; m_forced = 1'b1; end
    end else begin
      m_rule = pick(5'b11111);
    end
    m_pat = pattern(m_rule);
    chk("ctrl_pc",     32'(bus.ctrl_pc_o),     32'(m_pat[9:8]));
    chk("ctrl_if_id",  32'(bus.ctrl_if_id_o),  32'(m_pat[7:6]));
    chk("ctrl_id_ex",  32'(bus.ctrl_id_ex_o),  32'(m_pat[5:4]));
    chk("ctrl_ex_mem", 32'(bus.ctrl_ex_mem_o), 32'(m_pat[3:2]));
    chk("ctrl_mem_wb", 32'(bus.ctrl_mem_wb_o), 32'(m_pat[1:0]));
    chk("stall_cnt",   32'(bus.stall_cnt_o),   32'(m_cnt));
    chk("err_timeout", 32'(bus.err_timeout_o), 32'(m_err));
  endtask

  task automatic cycle_end();
    if (rst) begin
      m_in_mem = 1'b0; m_in_md = 1'b0; m_waited = 0; m_cnt = 0; m_err = 1'b0;
    end else begin
      if (m_pat[9:8] == S && m_cnt < CNT_MAX) m_cnt++;
      if (m_timeout) m_err = 1'b1;
      if (m_forced) begin
        m_waited++;
      end else begin
        m_in_mem = (m_rule == 1);
        m_in_md  = (m_rule == 2);
        m_waited = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    cycle_check();
    cycle_end();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int ready_bias;
    bit hit;
    set_idle();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // T1: reset holds everything at Bubble, then idle pipeline runs Default
    cycle_check();
    chk("t1_rst_pc",    32'(bus.ctrl_pc_o),     32'(B));
    chk("t1_rst_memwb", 32'(bus.ctrl_mem_wb_o), 32'(B));
    chk("t1_rst_cnt",   32'(bus.stall_cnt_o),   32'd0);
    cycle_end();
    rst = 1'b0;
    cycle_check();
    chk("t1_run_pc", 32'(bus.ctrl_pc_o), 32'(D));
    cycle_end();

    // T2: load-use on rs1, then the same with rd = x0
    set_load_use(5'd5);
    cycle_check();
    chk("t2_pc",    32'(bus.ctrl_pc_o),    32'(S));
    chk("t2_if_id", 32'(bus.ctrl_if_id_o), 32'(S));
    chk("t2_id_ex", 32'(bus.ctrl_id_ex_o), 32'(B));
    cycle_end();
    bus.ex_rd_addr_i  = 5'd0;
    bus.id_rs1_addr_i = 5'd0;
    cycle_check();
    chk("t2_x0_pc",  32'(bus.ctrl_pc_o),  32'(D));
    chk("t2_x0_cnt", 32'(bus.stall_cnt_o), 32'd1);
    cycle_end();

    // T3: branch and load-use together
    set_load_use(5'd5);
    bus.branch_taken_i = 1'b1;
    cycle_check();
    chk("t3_pc",    32'(bus.ctrl_pc_o),    32'(D));
    chk("t3_if_id", 32'(bus.ctrl_if_id_o), 32'(B));
    chk("t3_id_ex", 32'(bus.ctrl_id_ex_o), 32'(B));
    cycle_end();
    set_idle();

    // T4: three cycles of memory wait, then ready
    bus.mem_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle_check();
      chk("t4_wait_memwb", 32'(bus.ctrl_mem_wb_o), 32'(B));
      cycle_end();
    end
    bus.mem_ready_i = 1'b1;
    cycle_check();
    chk("t4_done_pc", 32'(bus.ctrl_pc_o), 32'(D));
    cycle_end();
    set_idle();
    step();

    // T5: mul/div wait whose completion collides with a memory stall
    bus.md_start_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    bus.md_done_i = 1'b1;
    bus.mem_req_i = 1'b1;
    cycle_check();
    chk("t5_collide_exmem", 32'(bus.ctrl_ex_mem_o), 32'(S));
    cycle_end();
    bus.md_start_i  = 1'b0;
    bus.md_done_i   = 1'b0;
    bus.mem_ready_i = 1'b1;
    step();
    set_idle();
    step();

    // Stall counter saturation
    set_load_use(5'd7);
    bus.id_rs1_addr_i = 5'd7;
    for (int i = 0; i < CNT_MAX + 8; i++) step();
    cycle_check();
    chk("sat_cnt", 32'(bus.stall_cnt_o), 32'(CNT_MAX));
    cycle_end();
    set_idle();

    // T6: memory never ready; watchdog trips, then reset clears it
    bus.mem_req_i = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 3 * TIMEOUT && !hit; i++) begin
      cycle_check();
      hit = m_timeout;
      cycle_end();
    end
    chk("t6_watchdog_reached", 32'(hit), 32'd1);
    bus.mem_req_i = 1'b0;
    cycle_check();
    chk("t6_err", 32'(bus.err_timeout_o), 32'd1);
    cycle_end();
    rst = 1'b1;
    step();
    rst = 1'b0;
    cycle_check();
    chk("t6_err_cleared", 32'(bus.err_timeout_o), 32'd0);
    chk("t6_cnt_cleared", 32'(bus.stall_cnt_o),   32'd0);
    cycle_end();

    // Random traffic with a varying memory-ready bias so long waits and timeouts occur
    ready_bias = 5;
    for (int i = 0; i < 1500; i++) begin
      if (i % 60 == 0) ready_bias = $urandom_range(0, 9);
      rst                = ($urandom_range(0, 99) == 0);
      bus.id_rs1_addr_i  = 5'($urandom_range(0, 3));
      bus.id_rs2_addr_i  = 5'($urandom_range(0, 3));
      bus.id_use_rs1_i   = 1'($urandom);
      bus.id_use_rs2_i   = 1'($urandom);
      bus.ex_is_load_i   = ($urandom_range(0, 2) == 0);
      bus.ex_rd_addr_i   = 5'($urandom_range(0, 3));
      bus.ex_wreg_i      = ($urandom_range(0, 3) != 0);
      bus.branch_taken_i = ($urandom_range(0, 5) == 0);
      bus.mem_req_i      = ($urandom_range(0, 3) == 0);
      bus.mem_ready_i    = ($urandom_range(0, 9) < ready_bias);
      bus.md_start_i     = ($urandom_range(0, 4) == 0);
      bus.md_done_i      = ($urandom_range(0, 9) < ready_bias);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
